// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: byte input, event FIFO output and arrow-level bundle for the PS/2 key decoder
interface ps2_key_decoder_if #(parameter int DEPTH = 8);
    logic [7:0]             rx_data;
    logic                   read_data;
    logic                   ev_pop;
    logic                   ev_valid;
    logic [9:0]             ev_data;
    logic [$clog2(DEPTH):0] ev_count;
    logic                   overflow;
    logic                   key_up;
    logic                   key_down;
    logic                   key_left;
    logic                   key_right;

    modport master (
        output rx_data, read_data, ev_pop,
        input  ev_valid, ev_data, ev_count, overflow, key_up, key_down, key_left, key_right
    );

    modport slave (
        input  rx_data, read_data, ev_pop,
        output ev_valid, ev_data, ev_count, overflow, key_up, key_down, key_left, key_right
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: strips PS/2 prefix bytes, queues make/break events in a FWFT FIFO, tracks arrow keys
module ps2_key_decoder #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input logic               clk,
    input logic               reset,
    ps2_key_decoder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] EXT     = 3'd1;
    localparam logic [2:0] BRK     = 3'd2;
    localparam logic [2:0] EXT_BRK = 3'd3;
    localparam logic [2:0] PAUSE   = 3'd4;

    logic [2:0]    state, cur, nstate;
    logic [2:0]    skip, nskip;
    logic [TW-1:0] idle_cnt;
    logic          timed_out;
    logic [7:0]    b;
    logic          junk, fake;
    logic          push;
    logic [9:0]    ev;
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, do_pop, do_push, overflow;
    logic [3:0]    keys;

    assign b         = bus.rx_data;
    assign timed_out = (state != IDLE) && (idle_cnt == TMAX);
    assign junk      = b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    assign fake      = (b == 8'h12) || (b == 8'h59);

    // Next-state and event decode; a timed-out prefix is treated as IDLE so a same-cycle byte decodes fresh
    always_comb begin
        cur    = timed_out ? IDLE : state;
        nstate = cur;
        nskip  = skip;
        push   = 1'b0;
        ev     = {2'b00, b};
        if (bus.read_data) begin
            case (cur)
                IDLE: begin
                    nstate = (b == 8'hE0) ? EXT : (b == 8'hF0) ? BRK : (b == 8'hE1) ? PAUSE : IDLE;
                    nskip  = (b == 8'hE1) ? 3'd7 : skip;
                    push   = (nstate == IDLE) && !junk;
                end
                EXT: begin
                    nstate = (b == 8'hF0) ? EXT_BRK : IDLE;
                    push   = (b != 8'hF0) && !fake;
                    ev     = {2'b10, b};
                end
                BRK: begin
                    nstate = IDLE;
                    push   = (b != 8'hE0) && (b != 8'hF0);
                    ev     = {2'b01, b};
                end
                EXT_BRK: begin
                    nstate = IDLE;
                    push   = !fake;
                    ev     = {2'b11, b};
                end
                PAUSE: begin
                    nskip  = skip - 1'b1;
                    push   = (skip == 3'd1);
                    nstate = push ? IDLE : PAUSE;
                    ev     = 10'h277;
                end
                default: nstate = IDLE;
            endcase
        end
    end

    // Prefix FSM and saturating idle-cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            skip     <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= nstate;
            skip     <= nskip;
            idle_cnt <= bus.read_data ? '0 : (idle_cnt == TMAX) ? idle_cnt : idle_cnt + 1'b1;
        end
    end

    // Arrow levels follow every decoded event, independent of whether the FIFO accepted it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keys <= '0;
        end else begin
            keys[3] <= (push && ev[9] && ev[7:0] == 8'h75) ? !ev[8] : keys[3];
            keys[2] <= (push && ev[9] && ev[7:0] == 8'h72) ? !ev[8] : keys[2];
            keys[1] <= (push && ev[9] && ev[7:0] == 8'h6B) ? !ev[8] : keys[1];
            keys[0] <= (push && ev[9] && ev[7:0] == 8'h74) ? !ev[8] : keys[0];
        end
    end

    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = bus.ev_pop && (count != '0);
    assign do_push = push && (!full || do_pop);

    // Circular event FIFO; a pop frees the slot a same-cycle push needs when full
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) mem[wr_ptr] <= ev;
            wr_ptr   <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr   <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count    <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            overflow <= overflow || (push && !do_push);
        end
    end

    assign bus.ev_valid  = (count != '0);
    assign bus.ev_data   = mem[rd_ptr];
    assign bus.ev_count  = count;
    assign bus.overflow  = overflow;
    assign bus.key_up    = keys[3];
    assign bus.key_down  = keys[2];
    assign bus.key_left  = keys[1];
    assign bus.key_right = keys[0];
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed PS/2 byte sequences with a queue scoreboard checked by an event monitor
module tb_ps2_key_decoder;
    localparam int DEPTH = 8;
    localparam int TO    = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ps2_key_decoder_if #(.DEPTH(DEPTH)) bus();

    ps2_key_decoder #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [9:0] exp_q[$];
    bit         pop_en = 1'b0;
    int         n_cmp  = 0;
    int         n_err  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] v);
        bus.rx_data   = v;
        bus.read_data = 1'b1;
        @(posedge clk);
        #1;
        bus.read_data = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        pop_en = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() != 0 || bus.ev_valid); i++) idle(1);
        chk("drain_empty", 32'({exp_q.size() != 0, bus.ev_valid}), 32'd0);
    endtask

    function automatic logic [31:0] keys();
        return 32'({bus.key_up, bus.key_down, bus.key_left, bus.key_right});
    endfunction

    // Monitor: pops and compares the head event whenever the consumer side is enabled
    initial begin
        bus.ev_pop = 1'b0;
        forever begin
            @(negedge clk);
            bus.ev_pop = 1'b0;
            if (reset && pop_en && bus.ev_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event: got %0h expected none", bus.ev_data);
                end else begin
                    chk("event", 32'(bus.ev_data), 32'(exp_q.pop_front()));
                end
                bus.ev_pop = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pause_seq [8];
        bus.rx_data   = 8'h00;
        bus.read_data = 1'b0;
        idle(2);
        chk("rst_valid", 32'(bus.ev_valid), 32'd0);
        chk("rst_count", 32'(bus.ev_count), 32'd0);
        chk("rst_data", 32'(bus.ev_data), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_keys", keys(), 32'd0);
        reset = 1'b1;
        idle(1);

        pop_en = 1'b0;
        exp_q.push_back(10'h01C);
        strobe(8'h1C);
        chk("make_head", 32'(bus.ev_data), 32'h01C);
        chk("make_valid", 32'(bus.ev_valid), 32'd1);
        exp_q.push_back(10'h11C);
        strobe(8'hF0);
        strobe(8'h1C);
        chk("count_two", 32'(bus.ev_count), 32'd2);
        pop_en = 1'b1;
        idle(3);
        chk("popped_empty", 32'(bus.ev_valid), 32'd0);
        drain();

        exp_q.push_back(10'h275);
        strobe(8'hE0); strobe(8'h75);
        chk("up_make", keys(), 32'b1000);
        exp_q.push_back(10'h375);
        strobe(8'hE0); strobe(8'hF0); strobe(8'h75);
        chk("up_break", keys(), 32'b0000);
        exp_q.push_back(10'h272);
        strobe(8'hE0); strobe(8'h72);
        chk("down_make", keys(), 32'b0100);
        exp_q.push_back(10'h26B);
        strobe(8'hE0); strobe(8'h6B);
        chk("left_make", keys(), 32'b0110);
        exp_q.push_back(10'h372);
        exp_q.push_back(10'h36B);
        strobe(8'hE0); strobe(8'hF0); strobe(8'h72);
        strobe(8'hE0); strobe(8'hF0); strobe(8'h6B);
        exp_q.push_back(10'h274);
        exp_q.push_back(10'h274);
        strobe(8'hE0); strobe(8'h74);
        strobe(8'hE0); strobe(8'h74);
        chk("right_typematic", keys(), 32'b0001);
        exp_q.push_back(10'h374);
        strobe(8'hE0); strobe(8'hF0); strobe(8'h74);
        chk("right_break", keys(), 32'b0000);
        strobe(8'hE0); strobe(8'h12);
        strobe(8'hAA);
        strobe(8'hE0); strobe(8'hF0); strobe(8'h12);
        strobe(8'hF0); strobe(8'hE0);
        drain();
        chk("discard_count", 32'(bus.ev_count), 32'd0);

        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        exp_q.push_back(10'h277);
        foreach (pause_seq[i]) strobe(pause_seq[i]);
        exp_q.push_back(10'h01C);
        strobe(8'h1C);
        drain();

        pop_en = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            logic [7:0] c;
            c = 8'h15 + 8'(i);
            if (i < DEPTH) exp_q.push_back({2'b00, c});
            strobe(c);
        end
        chk("full_count", 32'(bus.ev_count), 32'(DEPTH));
        chk("full_ovf", 32'(bus.overflow), 32'd1);
        chk("full_head", 32'(bus.ev_data), 32'h015);
        exp_q.push_back(10'h02A);
        pop_en = 1'b1;
        bus.rx_data   = 8'h2A;
        bus.read_data = 1'b1;
        @(posedge clk);
        #1;
        bus.read_data = 1'b0;
        pop_en = 1'b0;
        chk("pushpop_count", 32'(bus.ev_count), 32'(DEPTH));
        chk("pushpop_ovf", 32'(bus.overflow), 32'd1);
        chk("pushpop_head", 32'(bus.ev_data), 32'h016);
        drain();

        exp_q.push_back(10'h11C);
        strobe(8'hF0); idle(TO - 1); strobe(8'h1C);
        exp_q.push_back(10'h01C);
        strobe(8'hF0); idle(TO); strobe(8'h1C);
        exp_q.push_back(10'h075);
        strobe(8'hE0); idle(TO); strobe(8'h75);
        chk("timeout_ext_keys", keys(), 32'd0);
        drain();

        pop_en = 1'b0;
        strobe(8'h1C);
        strobe(8'hE0); strobe(8'h75);
        strobe(8'h22);
        chk("pre_reset_count", 32'(bus.ev_count), 32'd3);
        chk("pre_reset_up", keys(), 32'b1000);
        strobe(8'hE0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.ev_valid), 32'd0);
        chk("mid_rst_count", 32'(bus.ev_count), 32'd0);
        chk("mid_rst_data", 32'(bus.ev_data), 32'd0);
        chk("mid_rst_keys", keys(), 32'd0);
        exp_q.delete();
        idle(2);
        reset = 1'b1;
        pop_en = 1'b1;
        exp_q.push_back(10'h075);
        strobe(8'h75);
        chk("post_rst_up", keys(), 32'd0);
        drain();
        chk("post_rst_ovf", 32'(bus.overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
